// File: rtl/gate_check_pkg.sv
// rtl/gate_check_pkg.sv - shared types and truth-table constants for gate_checker
// Purpose: FSM state encoding and canonical 2-input gate truth tables.
// Truth tables use bit i for input vector i, where i = {a, b}.
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for a single asynchronous bit
// Ports:
//   clk   - sampling clock
//   rst_n - asynchronous active-low reset, both flops clear to 0
//   d     - asynchronous input
//   q     - synchronized output, two clocks of latency
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gate_checker.sv
// rtl/gate_checker.sv - exhaustive checker for a 2-input gate against a truth table
// Ports:
//   clk, rst_n   - clock and asynchronous active-low reset
//   start        - one-cycle request to begin a run (ignored while busy or in DONE)
//   truth_table  - expected output per input vector, latched at start
//   gut_a, gut_b - drives to the gate under test, gut_a = idx[1], gut_b = idx[0]
//   gut_out      - asynchronous gate output, synchronized before use
//   busy, done   - run in progress / one-cycle end-of-run pulse
//   pass, err_count, fail_mask - results of the last completed run
module gate_checker
  import gate_check_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] truth_table,
  output logic       gut_a,
  output logic       gut_b,
  input  logic       gut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  // The start edge itself moves the pins away from the previous run's (1,1),
  // so the first vector's settle window includes that acceptance cycle:
  // the counter is loaded with SETTLE_CYCLES and runs down to 0. Later
  // vectors reload with SETTLE_CYCLES-1, giving exactly SETTLE_CYCLES cycles.
  localparam logic [3:0] SETTLE_LOAD   = 4'(SETTLE_CYCLES);
  localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] idx;
  logic [3:0] cnt;
  logic [3:0] latched_tt;
  logic       sync_out;
  logic       mismatch;
  logic [2:0] err_next;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gut_out),
    .q     (sync_out)
  );

  assign gut_a    = idx[1];
  assign gut_b    = idx[0];
  assign mismatch = sync_out ^ latched_tt[idx];
  assign err_next = err_count + {2'b00, mismatch};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 2'd0;
      cnt        <= 4'd0;
      latched_tt <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 3'd0;
      fail_mask  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            latched_tt <= truth_table;
            err_count  <= 3'd0;
            fail_mask  <= 4'd0;
            pass       <= 1'b0;
            idx        <= 2'd0;
            busy       <= 1'b1;
            cnt        <= SETTLE_LOAD;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == 4'd0) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            fail_mask[idx] <= 1'b1;
          end
          err_count <= err_next;
          if (idx == 2'd3) begin
            // pass uses the count including this final comparison
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 3'd0);
            state <= DONE;
          end else begin
            idx   <= idx + 2'd1;
            cnt   <= SETTLE_RELOAD;
            state <= SETTLE;
          end
        end
        DONE: begin
          // start is deliberately not looked at here
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_checker.sv
// tb/tb_gate_checker.sv - scoreboard testbench for gate_checker
module tb_gate_checker;
  import gate_check_pkg::*;

  typedef struct {
    int         done_cyc;
    logic       pass;
    logic [2:0] err;
    logic [3:0] fm;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // instance 0 uses SETTLE_CYCLES=4, instance 1 uses SETTLE_CYCLES=2
  logic       rst_n_s   [2];
  logic       start_s   [2];
  logic [3:0] tt_s      [2];
  logic [3:0] model_s   [2];
  logic       gut_a_s   [2];
  logic       gut_b_s   [2];
  logic       gut_out_s [2];
  logic       busy_s    [2];
  logic       done_s    [2];
  logic       pass_s    [2];
  logic [2:0] err_s     [2];
  logic [3:0] fm_s      [2];

  exp_t sb_q [2][$];
  exp_t last_exp [2];
  int   done_cnt [2];

  genvar g;
  for (g = 0; g < 2; g++) begin : g_dut
    localparam int S = (g == 0) ? 4 : 2;
    // gate-under-test model: model_s is the gate's own truth table
    assign gut_out_s[g] = model_s[g][{gut_a_s[g], gut_b_s[g]}];
    gate_checker #(.SETTLE_CYCLES(S)) dut (
      .clk         (clk),
      .rst_n       (rst_n_s[g]),
      .start       (start_s[g]),
      .truth_table (tt_s[g]),
      .gut_a       (gut_a_s[g]),
      .gut_b       (gut_b_s[g]),
      .gut_out     (gut_out_s[g]),
      .busy        (busy_s[g]),
      .done        (done_s[g]),
      .pass        (pass_s[g]),
      .err_count   (err_s[g]),
      .fail_mask   (fm_s[g])
    );
  end

  function automatic int settle_of(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (done_s[i]) begin
        exp_t e;
        done_cnt[i]++;
        if (sb_q[i].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done inst=%0d actual=1 expected=0", i);
        end else begin
          e = sb_q[i].pop_front();
          chk($sformatf("done_cycle[%0d]", i), cyc, e.done_cyc);
          chk($sformatf("pass[%0d]", i), int'(pass_s[i]), int'(e.pass));
          chk($sformatf("err_count[%0d]", i), int'(err_s[i]), int'(e.err));
          chk($sformatf("fail_mask[%0d]", i), int'(fm_s[i]), int'(e.fm));
          chk($sformatf("busy_at_done[%0d]", i), int'(busy_s[i]), 0);
        end
      end
    end
  end

  task automatic issue(input int i, input logic [3:0] model, input logic [3:0] tbl);
    exp_t e;
    @(negedge clk);
    model_s[i] = model;
    tt_s[i]    = tbl;
    start_s[i] = 1'b1;
    // accepting edge T = cyc+1; done visible after edge T+1+4*(S+1)
    e.done_cyc = cyc + 2 + 4 * (settle_of(i) + 1);
    e.fm       = model ^ tbl;
    e.err      = 3'($countones(e.fm));
    e.pass     = (e.fm == 4'd0);
    sb_q[i].push_back(e);
    last_exp[i] = e;
    @(negedge clk);
    start_s[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    while (sb_q[i].size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb_q[i].size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout inst=%0d actual=none expected=done_pulse", i);
      sb_q[i].delete();
    end
    @(negedge clk);
  endtask

  task automatic check_hold(input int i);
    repeat (5) @(negedge clk);
    chk("hold_err", int'(err_s[i]), int'(last_exp[i].err));
    chk("hold_fm", int'(fm_s[i]), int'(last_exp[i].fm));
    chk("hold_pass", int'(pass_s[i]), int'(last_exp[i].pass));
    chk("hold_gut_a", int'(gut_a_s[i]), 1);
    chk("hold_gut_b", int'(gut_b_s[i]), 1);
    chk("hold_busy", int'(busy_s[i]), 0);
  endtask

  task automatic check_zero(input int i, input string tag);
    chk({tag, "_busy"}, int'(busy_s[i]), 0);
    chk({tag, "_done"}, int'(done_s[i]), 0);
    chk({tag, "_pass"}, int'(pass_s[i]), 0);
    chk({tag, "_err"}, int'(err_s[i]), 0);
    chk({tag, "_fm"}, int'(fm_s[i]), 0);
    chk({tag, "_gut_a"}, int'(gut_a_s[i]), 0);
    chk({tag, "_gut_b"}, int'(gut_b_s[i]), 0);
  endtask

  initial begin
    int dc;
    int n;
    for (int i = 0; i < 2; i++) begin
      rst_n_s[i] = 1'b0;
      start_s[i] = 1'b0;
      tt_s[i]    = 4'd0;
      model_s[i] = 4'd0;
    end
    repeat (3) @(negedge clk);
    check_zero(0, "reset0");
    check_zero(1, "reset1");
    rst_n_s[0] = 1'b1;
    rst_n_s[1] = 1'b1;

    // correct OR gate
    issue(0, TT_OR, TT_OR);
    drain(0);
    check_hold(0);

    // AND gate checked against OR table
    issue(0, TT_AND, TT_OR);
    drain(0);
    check_hold(0);

    // output stuck at 1 against XOR table
    issue(0, 4'b1111, TT_XOR);
    drain(0);

    // extra starts while busy, table changes mid-run, start during DONE
    dc = done_cnt[0];
    issue(0, TT_NAND, TT_OR);
    repeat (3) @(negedge clk);
    tt_s[0] = TT_AND;
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (6) @(negedge clk);
    tt_s[0] = TT_NOR;
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (done_s[0]) begin
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        break;
      end
    end
    chk("done_seen_busy_test", int'(n < 60), 1);
    repeat (40) @(negedge clk);
    chk("single_done_pulse", done_cnt[0] - dc, 1);
    chk("idle_after_dropped_start", int'(busy_s[0]), 0);
    chk("queue_empty", sb_q[0].size(), 0);

    // reset asserted while vector 2 is applied
    issue(0, TT_OR, TT_OR);
    n = 0;
    while (!(gut_a_s[0] && !gut_b_s[0]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reached_vector2", int'(n < 100), 1);
    repeat (2) @(negedge clk);
    sb_q[0].delete();
    dc = done_cnt[0];
    rst_n_s[0] = 1'b0;
    #1;
    check_zero(0, "midrun_reset");
    repeat (30) @(negedge clk);
    rst_n_s[0] = 1'b1;
    chk("no_done_after_abort", done_cnt[0] - dc, 0);
    issue(0, TT_OR, TT_OR);
    drain(0);
    check_hold(0);

    // short settle, correct NOR gate
    issue(1, TT_NOR, TT_NOR);
    drain(1);
    check_hold(1);

    // randomized runs on both instances
    for (int k = 0; k < 24; k++) begin
      int inst;
      logic [3:0] tbl;
      logic [3:0] mdl;
      inst = int'($urandom_range(0, 1));
      tbl  = 4'($urandom);
      mdl  = ($urandom_range(0, 2) == 0) ? tbl : 4'($urandom);
      issue(inst, mdl, tbl);
      drain(inst);
      if (k % 6 == 5) check_hold(inst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_checker.md
GATE_CHECKER -- requirements
Module: gate_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, giving the clocks each input vector is held before sampling; legal range 2..15.
REQ-002 SHALL have port clk  input  1  single clock; all flops on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a check run.
REQ-005 SHALL have port truth_table  input  4  expected gate output, with bit i for input vector i.
REQ-006 SHALL have port gut_a  output  1  drive to gate-under-test input a.
REQ-007 SHALL have port gut_b  output  1  drive to gate-under-test input b.
REQ-008 SHALL have port gut_out  input  1  gate-under-test output, treated as asynchronous.
REQ-009 SHALL have port busy  output  1  high while a run is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at the end of a run.
REQ-011 SHALL have port pass  output  1  high when the last run had zero mismatches.
REQ-012 SHALL have port err_count  output  3  mismatch count of the last run, range 0..4.
REQ-013 SHALL have port fail_mask  output  4  bit i set when vector i mismatched.

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, SAMPLE and DONE.
REQ-015 SHALL map vector index idx (2 bits) as gut_a=idx[1] and gut_b=idx[0], applied in order 0,1,2,3.
REQ-016 In IDLE with start=1 at edge T, SHALL latch truth_table, clear err_count, fail_mask and pass, set idx=0 and busy=1, load the settle counter, and enter SETTLE.
REQ-017 SHALL pass gut_out through a 2-flop synchronizer before any comparison.
REQ-018 SHALL remain in SETTLE for exactly SETTLE_CYCLES cycles, then spend one cycle in SAMPLE.
REQ-019 In SAMPLE, SHALL compare the synchronized gut_out with latched_tt[idx]; on mismatch it SHALL set fail_mask[idx] and increment err_count.
REQ-020 After SAMPLE with idx<3, SHALL increment idx, reload the counter and return to SETTLE; gut_a and gut_b SHALL change only at that transition.
REQ-021 After SAMPLE with idx=3, SHALL enter DONE; DONE SHALL last one cycle with done=1, busy=0, and pass=(err_count==0), then return to IDLE.
REQ-022 done SHALL be high exactly in the cycle following edge T+1+4*(SETTLE_CYCLES+1).
REQ-023 SHALL ignore start while busy=1 or in DONE; a start in the same cycle as DONE SHALL be dropped.
REQ-024 Changes to truth_table during a run SHALL NOT affect that run.
REQ-025 err_count, fail_mask and pass SHALL hold their values in IDLE until the next accepted start.
REQ-026 gut_a and gut_b SHALL hold vector 3 (1,1) after a run until the next start.

Reset
REQ-027 On rst_n=0, SHALL immediately enter IDLE and set busy=0, done=0, pass=0, err_count=0, fail_mask=0, gut_a=0, gut_b=0, idx=0, and clear the counter and synchronizer.
REQ-028 Reset asserted mid-run SHALL abort the run with no done pulse; the first start after release SHALL begin a fresh run.

Structure
REQ-029 Package gate_check_pkg SHALL hold the FSM state typedef and truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111, and TT_NOR=4'b0001.
REQ-030 The 2-flop synchronizer SHALL be a separate sub-module named sync2 with clk and rst_n ports, reset value 0.

Verification
REQ-031 Bench SHALL cover: correct OR model on gut_a/gut_b, start with TT_OR, SETTLE_CYCLES=4 -> done in cycle T+21, pass=1, err_count=0, fail_mask=0.
REQ-032 Bench SHALL cover: AND model checked against TT_OR -> pass=0, err_count=2, fail_mask=4'b0110.
REQ-033 Bench SHALL cover: gut_out stuck at 1 with TT_XOR -> err_count=2, fail_mask=4'b1001.
REQ-034 Bench SHALL cover: start pulsed again while busy, and truth_table changed mid-run -> a single done pulse with results from the latched table.
REQ-035 Bench SHALL cover: rst_n low during vector 2 -> all outputs 0 at once, no done pulse; a restart with a correct model then gives pass=1.
REQ-036 Bench SHALL cover: SETTLE_CYCLES=2 with TT_NOR and a correct NOR model -> pass=1, done in cycle T+13.
